// File: rtl/vga_rx_monitor.sv
// vga_rx_monitor: locks onto the incoming VGA sync timing, regenerates pixel
// coordinates, flags line/frame length errors, counts frames and captures the
// colour seen at a programmable probe coordinate.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_SEARCH | no trusted timing, waiting for the first hsync fall
// ST_HLOCK  | line length being verified, waiting for a vsync fall
// ST_LOCKED | line and frame timing trusted, pixels are reported
module vga_rx_monitor #(
  parameter int H_VISIBLE = 640,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int H_TOTAL   = 800,
  parameter int V_VISIBLE = 480,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int V_TOTAL   = 525
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  input  logic       vga_h_sync,
  input  logic       vga_v_sync,
  input  logic [2:0] vga_R,
  input  logic [2:0] vga_G,
  input  logic [1:0] vga_B,
  input  logic [9:0] probe_x,
  input  logic [9:0] probe_y,
  output logic       pix_valid,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic [7:0] pix_rgb,
  output logic [7:0] probe_rgb,
  output logic       probe_hit,
  output logic       locked,
  output logic       frame_done,
  output logic [7:0] frame_count,
  output logic       h_err,
  output logic       v_err
);

  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_START = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_END   = 10'(H_SYNC + H_BACK + H_VISIBLE - 1);
  localparam logic [9:0] V_START = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] V_END   = 10'(V_SYNC + V_BACK + V_VISIBLE - 1);
  localparam logic [9:0] CNT_MAX = 10'h3ff;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_HLOCK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [9:0] hcnt_q, hcnt_d;
  logic [9:0] vcnt_q, vcnt_d;
  logic       hs_prev_q, hs_prev_d;
  logic       vs_prev_q, vs_prev_d;
  logic [7:0] frame_count_q, frame_count_d;
  logic       pix_valid_q, pix_valid_d;
  logic [9:0] pix_x_q, pix_x_d;
  logic [9:0] pix_y_q, pix_y_d;
  logic [7:0] pix_rgb_q, pix_rgb_d;
  logic [7:0] probe_rgb_q, probe_rgb_d;
  logic       probe_hit_q, probe_hit_d;
  logic       frame_done_q, frame_done_d;
  logic       h_err_q, h_err_d;
  logic       v_err_q, v_err_d;

  logic       hfall, vfall;
  logic       line_bad, frame_bad;
  logic       in_window;
  logic [7:0] rgb_in;

  assign rgb_in = {vga_R, vga_G, vga_B};
  assign hfall  = hs_prev_q & ~vga_h_sync;
  assign vfall  = vs_prev_q & ~vga_v_sync;

  // A line is wrong if the fall comes early/late relative to the last count.
  assign line_bad  = hfall ? (hcnt_q != H_LAST) : (hcnt_q == H_LAST);
  assign frame_bad = vfall ? (vcnt_q != V_LAST) : (hfall && (vcnt_q == V_LAST));

  // Next-state, counters and registered outputs for one pixel-rate sample.
  always_comb begin
    state_d       = state_q;
    hcnt_d        = hcnt_q;
    vcnt_d        = vcnt_q;
    hs_prev_d     = hs_prev_q;
    vs_prev_d     = vs_prev_q;
    frame_count_d = frame_count_q;
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    pix_rgb_d     = pix_rgb_q;
    probe_rgb_d   = probe_rgb_q;
    pix_valid_d   = 1'b0;
    probe_hit_d   = 1'b0;
    frame_done_d  = 1'b0;
    h_err_d       = 1'b0;
    v_err_d       = 1'b0;
    in_window     = 1'b0;

    if (pix_en) begin
      hs_prev_d = vga_h_sync;
      vs_prev_d = vga_v_sync;

      if (hfall) begin
        hcnt_d = '0;
      end else if (hcnt_q != CNT_MAX) begin
        hcnt_d = hcnt_q + 10'd1;
      end

      if (vfall) begin
        vcnt_d = '0;
      end else if (hfall && (vcnt_q != CNT_MAX)) begin
        vcnt_d = vcnt_q + 10'd1;
      end

      case (state_q)
        ST_SEARCH: begin
          if (hfall) state_d = ST_HLOCK;
        end
        ST_HLOCK: begin
          if (line_bad) begin
            state_d = ST_SEARCH;
          end else if (vfall) begin
            state_d = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (line_bad || frame_bad) begin
            state_d = ST_SEARCH;
            h_err_d = line_bad;
            v_err_d = frame_bad;
          end else if (vfall) begin
            frame_done_d  = 1'b1;
            frame_count_d = frame_count_q + 8'd1;
          end
        end
        default: state_d = ST_SEARCH;
      endcase

      // Window test uses the counts this sample lands on, not the old ones.
      in_window = (hcnt_d >= H_START) && (hcnt_d <= H_END) &&
                  (vcnt_d >= V_START) && (vcnt_d <= V_END);

      if ((state_d == ST_LOCKED) && in_window) begin
        pix_valid_d = 1'b1;
        pix_x_d     = hcnt_d - H_START;
        pix_y_d     = vcnt_d - V_START;
        pix_rgb_d   = rgb_in;
        if ((pix_x_d == probe_x) && (pix_y_d == probe_y)) begin
          probe_hit_d = 1'b1;
          probe_rgb_d = rgb_in;
        end
      end
    end
  end

  // State and output registers; reset wins over pix_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_SEARCH;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      hs_prev_q     <= 1'b0;
      vs_prev_q     <= 1'b0;
      frame_count_q <= '0;
      pix_valid_q   <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_rgb_q     <= '0;
      probe_rgb_q   <= '0;
      probe_hit_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      h_err_q       <= 1'b0;
      v_err_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      hs_prev_q     <= hs_prev_d;
      vs_prev_q     <= vs_prev_d;
      frame_count_q <= frame_count_d;
      pix_valid_q   <= pix_valid_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      pix_rgb_q     <= pix_rgb_d;
      probe_rgb_q   <= probe_rgb_d;
      probe_hit_q   <= probe_hit_d;
      frame_done_q  <= frame_done_d;
      h_err_q       <= h_err_d;
      v_err_q       <= v_err_d;
    end
  end

  assign pix_valid   = pix_valid_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_rgb     = pix_rgb_q;
  assign probe_rgb   = probe_rgb_q;
  assign probe_hit   = probe_hit_q;
  assign locked      = (state_q == ST_LOCKED);
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;
  assign h_err       = h_err_q;
  assign v_err       = v_err_q;

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Bench for vga_rx_monitor with a shrunken raster so many frames fit in a
// short run; a sample-level reference model predicts every output each clock.
module tb_vga_rx_monitor;

  localparam int HV = 16, HS = 4, HB = 3, HT = 28;
  localparam int VV = 6,  VS = 2, VB = 3, VT = 13;

  logic       clk = 1'b0;
  logic       rst, pix_en, vga_h_sync, vga_v_sync;
  logic [2:0] vga_R, vga_G;
  logic [1:0] vga_B;
  logic [9:0] probe_x, probe_y;
  logic       pix_valid, probe_hit, locked, frame_done, h_err, v_err;
  logic [9:0] pix_x, pix_y;
  logic [7:0] pix_rgb, probe_rgb, frame_count;

  vga_rx_monitor #(
    .H_VISIBLE(HV), .H_SYNC(HS), .H_BACK(HB), .H_TOTAL(HT),
    .V_VISIBLE(VV), .V_SYNC(VS), .V_BACK(VB), .V_TOTAL(VT)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .vga_h_sync(vga_h_sync), .vga_v_sync(vga_v_sync),
    .vga_R(vga_R), .vga_G(vga_G), .vga_B(vga_B),
    .probe_x(probe_x), .probe_y(probe_y),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .probe_rgb(probe_rgb), .probe_hit(probe_hit), .locked(locked),
    .frame_done(frame_done), .frame_count(frame_count),
    .h_err(h_err), .v_err(v_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fails = 0;

  // Reference model state (0 = searching, 1 = line length trusted, 2 = locked)
  int m_h = 0, m_v = 0, m_trust = 0, m_fc = 0;
  bit m_hsp = 0, m_vsp = 0;
  int e_px = 0, e_py = 0, e_rgb = 0, e_prgb = 0;
  bit e_pv = 0, e_hit = 0, e_done = 0, e_herr = 0, e_verr = 0;

  // Generator state
  int g_h = 0, g_v = 0, line_len = HT, frame_lines = VT;
  int g_px = 5, g_py = 3, p_col = 8'hE0;
  bit every4 = 0;
  int clk_idx = 0;

  // Observation statistics
  int pv_cnt = 0, hit_cnt = 0, herr_cnt = 0, verr_cnt = 0, gap_pulses = 0, hits_before;
  bit first_pending = 1, gap_win = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit pe, input bit hs, input bit vs, input int rgb);
    bit hf, vf, line_bad, frame_bad;
    e_pv = 0; e_hit = 0; e_done = 0; e_herr = 0; e_verr = 0;
    if (r) begin
      m_h = 0; m_v = 0; m_hsp = 0; m_vsp = 0; m_trust = 0; m_fc = 0;
      e_px = 0; e_py = 0; e_rgb = 0; e_prgb = 0;
    end else if (pe) begin
      hf = m_hsp && !hs;
      vf = m_vsp && !vs;
      line_bad  = (hf != (m_h == HT - 1));
      frame_bad = vf ? (m_v != VT - 1) : (hf && (m_v == VT - 1));
      m_hsp = hs;
      m_vsp = vs;
      m_h = hf ? 0 : ((m_h < 1023) ? m_h + 1 : 1023);
      if (vf) m_v = 0;
      else if (hf && m_v < 1023) m_v = m_v + 1;
      if (m_trust == 0) begin
        if (hf) m_trust = 1;
      end else if (m_trust == 1) begin
        if (line_bad) m_trust = 0;
        else if (vf) m_trust = 2;
      end else begin
        if (line_bad || frame_bad) begin
          e_herr = line_bad; e_verr = frame_bad; m_trust = 0;
        end else if (vf) begin
          e_done = 1; m_fc = (m_fc + 1) % 256;
        end
      end
      if (m_trust == 2 && m_h >= HS + HB && m_h < HS + HB + HV &&
          m_v >= VS + VB && m_v < VS + VB + VV) begin
        e_pv = 1;
        e_px = m_h - (HS + HB);
        e_py = m_v - (VS + VB);
        e_rgb = rgb;
        if (e_px == g_px && e_py == g_py) begin
          e_hit = 1; e_prgb = rgb;
        end
      end
    end
  endtask

  task automatic clk_step(input bit r, input bit pe);
    int gx, gy, rgb;
    logic [49:0] act, exp;
    @(negedge clk);
    rst = r;
    pix_en = pe;
    probe_x = 10'(g_px);
    probe_y = 10'(g_py);
    if (pe) begin
      vga_h_sync = (g_h >= HS);
      vga_v_sync = (g_v >= VS);
      gx = g_h - (HS + HB);
      gy = g_v - (VS + VB);
      rgb = (gx == g_px && gy == g_py) ? p_col : int'($urandom_range(0, 255));
    end else begin
      vga_h_sync = 1'($urandom_range(0, 1));
      vga_v_sync = 1'($urandom_range(0, 1));
      rgb = int'($urandom_range(0, 255));
    end
    {vga_R, vga_G, vga_B} = 8'(rgb);
    model_step(r, pe, vga_h_sync, vga_v_sync, rgb);
    @(posedge clk);
    #1;
    act = {pix_valid, pix_x, pix_y, pix_rgb, probe_rgb, probe_hit, locked,
           frame_done, frame_count, h_err, v_err};
    exp = {e_pv, 10'(e_px), 10'(e_py), 8'(e_rgb), 8'(e_prgb), e_hit, 1'(m_trust == 2),
           e_done, 8'(m_fc), e_herr, e_verr};
    check_val("outputs", 64'(act), 64'(exp));
    if (gap_win && (pix_valid || probe_hit || frame_done || h_err || v_err)) gap_pulses++;
    if (pix_valid) begin
      pv_cnt++;
      if (first_pending) begin
        check_val("first_pixel", 64'({pix_x, pix_y}), 64'(0));
        first_pending = 0;
      end
    end
    if (probe_hit) hit_cnt++;
    if (h_err) herr_cnt++;
    if (v_err) verr_cnt++;
    if (frame_done) begin
      check_val("frame_pixels", 64'(pv_cnt), 64'(HV * VV));
      pv_cnt = 0;
      first_pending = 1;
    end
    if (!locked) begin
      pv_cnt = 0;
      first_pending = 1;
    end
    if (pe) begin
      g_h++;
      if (g_h >= line_len) begin
        g_h = 0;
        line_len = HT;
        g_v++;
        if (g_v >= frame_lines) begin
          g_v = 0;
          frame_lines = VT;
        end
      end
    end
  endtask

  // Runs until n enabled samples have been delivered to the monitor.
  task automatic run_samples(input int n, input bit r = 1'b0);
    int done;
    bit pe;
    done = 0;
    while (done < n) begin
      clk_idx++;
      pe = every4 ? (clk_idx % 4 == 3) : ($urandom_range(0, 3) != 0);
      clk_step(r, pe);
      if (pe) done++;
    end
  endtask

  initial begin
    rst = 1'b1; pix_en = 1'b0; vga_h_sync = 1'b0; vga_v_sync = 1'b0;
    vga_R = '0; vga_G = '0; vga_B = '0; probe_x = '0; probe_y = '0;
    repeat (3) clk_step(1'b1, 1'b0);
    check_val("reset_state",
              64'({pix_valid, pix_x, pix_y, pix_rgb, probe_rgb, probe_hit, locked,
                   frame_done, frame_count, h_err, v_err}), 64'(0));

    // Clean frames, pix_en every 4th clk, probe at (5,3) in red
    every4 = 1;
    run_samples(5 * HT * VT);
    every4 = 0;
    check_val("lock_clean", 64'(locked), 64'(1));
    check_val("fc_clean", 64'(frame_count), 64'(3));
    check_val("hits_clean", 64'(hit_cnt), 64'(4));
    check_val("probe_red", 64'(probe_rgb), 64'(8'hE0));
    check_val("errs_clean", 64'(herr_cnt + verr_cnt), 64'(0));

    // Probe moved to the last visible pixel
    g_px = HV - 1; g_py = VV - 1; p_col = 8'h03;
    run_samples(2 * HT * VT);
    check_val("probe_corner", 64'(probe_rgb), 64'(8'h03));
    check_val("hits_corner", 64'(hit_cnt), 64'(6));
    check_val("fc_corner", 64'(frame_count), 64'(5));

    // One line a pixel short while locked
    run_samples(5 * HT);
    line_len = HT - 1;
    run_samples((VT - 5) * HT - 1 + 2 * HT * VT);
    check_val("herr_count", 64'(herr_cnt), 64'(1));
    check_val("verr_none", 64'(verr_cnt), 64'(0));
    check_val("fc_after_herr", 64'(frame_count), 64'(7));
    check_val("relock_herr", 64'(locked), 64'(1));

    // One frame a line short while locked
    frame_lines = VT - 1;
    run_samples((VT - 1) * HT + 2 * HT * VT);
    check_val("verr_count", 64'(verr_cnt), 64'(1));
    check_val("herr_same", 64'(herr_cnt), 64'(1));
    check_val("fc_after_verr", 64'(frame_count), 64'(8));
    check_val("relock_verr", 64'(locked), 64'(1));

    // Reset mid-line, released on the first sample of a line (hsync low)
    run_samples((VT - 2) * HT + HT / 2);
    clk_step(1'b1, 1'b1);
    check_val("rst_outputs",
              64'({pix_valid, pix_x, pix_y, pix_rgb, probe_rgb, probe_hit, locked,
                   frame_done, frame_count, h_err, v_err}), 64'(0));
    run_samples(HT / 2 - 1, 1'b1);
    clk_step(1'b0, 1'b1);
    check_val("rst_release_unlocked", 64'(locked), 64'(0));
    run_samples(HT - 1 + HT * VT);
    check_val("no_early_lock", 64'(locked), 64'(0));
    run_samples(2 * HT * VT);
    check_val("relock_rst", 64'(locked), 64'(1));
    check_val("fc_after_rst", 64'(frame_count), 64'(1));
    check_val("probe_after_rst", 64'(probe_rgb), 64'(8'h03));

    // Out-of-range probe plus a long pix_en gap in the visible area
    g_px = HV; g_py = 2;
    hits_before = hit_cnt;
    run_samples(6 * HT + 10);
    gap_win = 1;
    repeat (1000) clk_step(1'b0, 1'b0);
    gap_win = 0;
    check_val("gap_pulses", 64'(gap_pulses), 64'(0));
    check_val("gap_locked", 64'(locked), 64'(1));
    run_samples(2 * HT * VT - (6 * HT + 10));
    check_val("fc_after_gap", 64'(frame_count), 64'(3));
    check_val("probe_oob_hits", 64'(hit_cnt), 64'(hits_before));
    check_val("errs_final", 64'(herr_cnt * 16 + verr_cnt), 64'(17));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
